// File: rtl/shift_pipe.sv
// shift_pipe: three-stage pipelined barrel shifter
// logical / arithmetic / rotate modes with carry and zero flags
module shift_pipe #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_arg,
   input  logic [WIDTH-1:0] in_amt,
   input  logic [1:0]       in_mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_carry,
   output logic             out_zero,
   output logic [TAG_W-1:0] out_tag
);
   localparam int LG = $clog2(WIDTH);

   function automatic logic [WIDTH-1:0] rotl(
      input logic [WIDTH-1:0] a,
      input logic [LG-1:0]    k
   );
      logic [2*WIDTH-1:0] t;
      t = {a, a} << k;
      return t[2*WIDTH-1:WIDTH];
   endfunction

   function automatic logic [WIDTH-1:0] rotr(
      input logic [WIDTH-1:0] a,
      input logic [LG-1:0]    k
   );
      logic [2*WIDTH-1:0] t;
      t = {a, a} >> k;
      return t[WIDTH-1:0];
   endfunction

   logic ld1, ld2, ld3;
   logic s1_v_q, s2_v_q, s3_v_q;

   // a stage may load when empty or when its content moves on
   always_comb begin
      ld3 = !s3_v_q || out_ready;
      ld2 = !s2_v_q || ld3;
      ld1 = !s1_v_q || ld2;
   end

   assign in_ready = ld1;

   logic [WIDTH:0] amt_x, mag_d;
   logic           sat_d, eq_d;

   // magnitude at WIDTH+1 bits so the most-negative amount is exact
   always_comb begin
      amt_x = {in_amt[WIDTH-1], in_amt};
      mag_d = in_amt[WIDTH-1] ? (~amt_x + (WIDTH+1)'(1)) : amt_x;
      sat_d = mag_d >= (WIDTH+1)'(WIDTH);
      eq_d  = mag_d == (WIDTH+1)'(WIDTH);
   end

   logic [WIDTH-1:0] s1_arg_q;
   logic [LG-1:0]    s1_amt_q;
   logic             s1_dir_q, s1_sat_q, s1_eq_q;
   logic [1:0]       s1_mode_q;
   logic [TAG_W-1:0] s1_tag_q;

   // S1: register decoded request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v_q    <= 1'b0;
         s1_arg_q  <= '0;
         s1_amt_q  <= '0;
         s1_dir_q  <= 1'b0;
         s1_sat_q  <= 1'b0;
         s1_eq_q   <= 1'b0;
         s1_mode_q <= '0;
         s1_tag_q  <= '0;
      end else begin
         if (ld1) s1_v_q <= in_valid;
         if (ld1 && in_valid) begin
            s1_arg_q  <= in_arg;
            s1_amt_q  <= mag_d[LG-1:0];
            s1_dir_q  <= in_amt[WIDTH-1];
            s1_sat_q  <= sat_d;
            s1_eq_q   <= eq_d;
            s1_mode_q <= in_mode;
            s1_tag_q  <= in_tag;
         end
      end
   end

   logic [LG-1:0]         crs;
   logic [WIDTH:0]        rsrc, s2_val_d;
   logic signed [WIDTH:0] sra1;

   // coarse shift by multiples of 4; a guard bit catches the carry
   always_comb begin
      crs      = {s1_amt_q[LG-1:2], 2'b00};
      rsrc     = {s1_arg_q, 1'b0};
      sra1     = $signed(rsrc) >>> crs;
      s2_val_d = {1'b0, s1_arg_q};
      unique case (s1_mode_q)
         2'b10: begin
            if (s1_dir_q) s2_val_d = {1'b0, rotr(s1_arg_q, crs)};
            else          s2_val_d = {1'b0, rotl(s1_arg_q, crs)};
         end
         2'b11: s2_val_d = {1'b0, s1_arg_q};
         2'b01: begin
            if (s1_dir_q) s2_val_d = sra1;
            else          s2_val_d = {1'b0, s1_arg_q} << crs;
         end
         default: begin
            if (s1_dir_q) s2_val_d = rsrc >> crs;
            else          s2_val_d = {1'b0, s1_arg_q} << crs;
         end
      endcase
   end

   logic [WIDTH:0]   s2_val_q;
   logic [1:0]       s2_fine_q, s2_mode_q;
   logic             s2_dir_q, s2_sat_q, s2_eq_q, s2_nz_q;
   logic             s2_msb_q, s2_lsb_q;
   logic [TAG_W-1:0] s2_tag_q;

   // S2: register coarse result and what S3 still needs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_v_q    <= 1'b0;
         s2_val_q  <= '0;
         s2_fine_q <= '0;
         s2_mode_q <= '0;
         s2_dir_q  <= 1'b0;
         s2_sat_q  <= 1'b0;
         s2_eq_q   <= 1'b0;
         s2_nz_q   <= 1'b0;
         s2_msb_q  <= 1'b0;
         s2_lsb_q  <= 1'b0;
         s2_tag_q  <= '0;
      end else begin
         if (ld2) s2_v_q <= s1_v_q;
         if (ld2 && s1_v_q) begin
            s2_val_q  <= s2_val_d;
            s2_fine_q <= s1_amt_q[1:0];
            s2_mode_q <= s1_mode_q;
            s2_dir_q  <= s1_dir_q;
            s2_sat_q  <= s1_sat_q;
            s2_eq_q   <= s1_eq_q;
            s2_nz_q   <= |s1_amt_q;
            s2_msb_q  <= s1_arg_q[WIDTH-1];
            s2_lsb_q  <= s1_arg_q[0];
            s2_tag_q  <= s1_tag_q;
         end
      end
   end

   logic [LG-1:0]         fin;
   logic [WIDTH:0]        shl, shr;
   logic signed [WIDTH:0] sra2;
   logic [WIDTH-1:0]      rot, s3_res_d;
   logic                  s3_cy_d;

   // fine shift, saturation and carry selection
   always_comb begin
      fin      = LG'(s2_fine_q);
      shl      = s2_val_q << s2_fine_q;
      shr      = s2_val_q >> s2_fine_q;
      sra2     = $signed(s2_val_q) >>> s2_fine_q;
      rot      = s2_dir_q ? rotr(s2_val_q[WIDTH-1:0], fin)
                          : rotl(s2_val_q[WIDTH-1:0], fin);
      s3_res_d = s2_val_q[WIDTH-1:0];
      s3_cy_d  = 1'b0;
      unique case (s2_mode_q)
         2'b10: begin
            s3_res_d = rot;
            s3_cy_d  = s2_nz_q & (s2_dir_q ? rot[WIDTH-1] : rot[0]);
         end
         2'b11: begin
            s3_res_d = s2_val_q[WIDTH-1:0];
            s3_cy_d  = 1'b0;
         end
         default: begin
            if (!s2_dir_q)        {s3_cy_d, s3_res_d} = shl;
            else if (s2_mode_q[0]) {s3_res_d, s3_cy_d} = sra2;
            else                  {s3_res_d, s3_cy_d} = shr;
            if (s2_sat_q) begin
               if (s2_mode_q[0] && s2_dir_q) begin
                  s3_res_d = {WIDTH{s2_msb_q}};
                  s3_cy_d  = s2_msb_q;
               end else begin
                  s3_res_d = '0;
                  s3_cy_d  = s2_eq_q & (s2_dir_q ? s2_msb_q : s2_lsb_q);
               end
            end
         end
      endcase
   end

   logic [WIDTH-1:0] s3_res_q;
   logic             s3_cy_q, s3_zero_q;
   logic [TAG_W-1:0] s3_tag_q;

   // S3: registered outputs, held while the consumer stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s3_v_q    <= 1'b0;
         s3_res_q  <= '0;
         s3_cy_q   <= 1'b0;
         s3_zero_q <= 1'b0;
         s3_tag_q  <= '0;
      end else begin
         if (ld3) s3_v_q <= s2_v_q;
         if (ld3 && s2_v_q) begin
            s3_res_q  <= s3_res_d;
            s3_cy_q   <= s3_cy_d;
            s3_zero_q <= s3_res_d == '0;
            s3_tag_q  <= s2_tag_q;
         end
      end
   end

   assign out_valid  = s3_v_q;
   assign out_result = s3_res_q;
   assign out_carry  = s3_cy_q;
   assign out_zero   = s3_zero_q;
   assign out_tag    = s3_tag_q;
endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: scoreboard bench for shift_pipe
// reference model derived from the shift rules, plus literal vectors
module tb_shift_pipe;
   logic        clk, rst_n;
   logic        in_valid, in_ready;
   logic [31:0] in_arg, in_amt;
   logic [1:0]  in_mode;
   logic [3:0]  in_tag;
   logic        out_valid, out_ready;
   logic [31:0] out_result;
   logic        out_carry, out_zero;
   logic [3:0]  out_tag;

   shift_pipe #(.WIDTH(32), .TAG_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_arg(in_arg), .in_amt(in_amt),
      .in_mode(in_mode), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_carry(out_carry),
      .out_zero(out_zero), .out_tag(out_tag)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [31:0] res;
      logic        c;
      logic        z;
      logic [3:0]  tag;
      int          acc;
      bit          ex;
      bit          lit;
      logic [31:0] lres;
      logic        lc;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   n_acc = 0;
   int   cyc   = 0;
   bit          cur_ex, cur_lit;
   logic [31:0] cur_lres;
   logic        cur_lc;
   bit          hold_v;
   logic [38:0] snap;

   logic [31:0] d_arg [20];
   logic [31:0] d_amt [20];
   logic [1:0]  d_mode[20];
   logic [31:0] d_res [20];
   logic        d_cy  [20];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // result and carry straight from the rules, bit by bit
   function automatic logic [32:0] model(input logic [31:0] a,
                                         input logic [31:0] amt,
                                         input logic [1:0] md);
      longint s, mag;
      int     k, m;
      bit     left;
      logic   c, fill;
      logic [31:0] r;
      s    = longint'($signed(amt));
      mag  = (s < 0) ? -s : s;
      left = (s > 0);
      r    = a;
      c    = 1'b0;
      if (md == 2'd3) begin
         r = a;
         c = 1'b0;
      end else if (md == 2'd2) begin
         k = int'(mag % 32);
         if (k != 0) begin
            for (int i = 0; i < 32; i++) begin
               if (left) r[(i + k) % 32] = a[i];
               else      r[i] = a[(i + k) % 32];
            end
            c = left ? r[0] : r[31];
         end
      end else if (mag != 0) begin
         fill = (md == 2'd1) ? a[31] : 1'b0;
         if (left) begin
            if (mag < 32) begin
               m = int'(mag);
               r = a << m;
               c = a[32 - m];
            end else begin
               r = '0;
               c = (mag == 32) ? a[0] : 1'b0;
            end
         end else begin
            if (mag < 32) begin
               m = int'(mag);
               for (int i = 0; i < 32; i++)
                  r[i] = (i + m < 32) ? a[i + m] : fill;
               c = a[m - 1];
            end else if (md == 2'd1) begin
               r = {32{fill}};
               c = fill;
            end else begin
               r = '0;
               c = (mag == 32) ? a[31] : 1'b0;
            end
         end
      end
      return {c, r};
   endfunction

   // compare process: scoreboard, latency and hold-stability checks
   initial begin
      exp_t        e;
      logic [32:0] mv;
      hold_v = 1'b0;
      snap   = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            q.delete();
            hold_v = 1'b0;
         end else begin
            if (hold_v)
               chk("hold", {out_valid, out_result, out_carry,
                            out_zero, out_tag}, snap);
            hold_v = out_valid && !out_ready;
            snap   = {out_valid, out_result, out_carry, out_zero, out_tag};
            if (out_valid && out_ready) begin
               if (q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_out: got tag %0h want none",
                           out_tag);
               end else begin
                  e = q.pop_front();
                  chk("res", out_result, e.res);
                  chk("carry", out_carry, e.c);
                  chk("zero", out_zero, e.z);
                  chk("tag", out_tag, e.tag);
                  if (e.ex) chk("latency", cyc - e.acc, 3);
                  else      chk("latency_min", (cyc - e.acc) >= 3, 1);
                  if (e.lit) begin
                     chk("lit_res", out_result, e.lres);
                     chk("lit_carry", out_carry, e.lc);
                     chk("lit_zero", out_zero, e.lres == 0);
                  end
               end
            end
            if (in_valid && in_ready) begin
               mv     = model(in_arg, in_amt, in_mode);
               e.res  = mv[31:0];
               e.c    = mv[32];
               e.z    = (mv[31:0] == 0);
               e.tag  = in_tag;
               e.acc  = cyc;
               e.ex   = cur_ex;
               e.lit  = cur_lit;
               e.lres = cur_lres;
               e.lc   = cur_lc;
               q.push_back(e);
               n_acc++;
            end
         end
      end
   end

   task automatic send(input logic [31:0] a, input logic [31:0] amt,
                       input logic [1:0] md, input logic [3:0] tg,
                       input bit ex, input bit lit,
                       input logic [31:0] lr, input logic lc);
      int n;
      n        = 0;
      cur_ex   = ex;
      cur_lit  = lit;
      cur_lres = lr;
      cur_lc   = lc;
      in_valid = 1'b1;
      in_arg   = a;
      in_amt   = amt;
      in_mode  = md;
      in_tag   = tg;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 100);
      if (!in_ready) begin
         n_cmp++;
         n_err++;
         $display("FAIL accept_timeout: got in_ready 0 want 1");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain_timeout: got %0d pending want 0", q.size());
      end
   endtask

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      rst_n = 1'b0; in_valid = 1'b0; in_arg = '0; in_amt = '0;
      in_mode = '0; in_tag = '0; out_ready = 1'b1;
      cur_ex = 0; cur_lit = 0; cur_lres = '0; cur_lc = 1'b0;
      d_arg = '{32'hF000000F, 32'hF000000F, 32'hF000000F, 32'hF000000F,
                32'hF000000F, 32'hF000000F, 32'hF000000F, 32'hF000000F,
                32'h80000000, 32'hF000000F, 32'hF000000F, 32'hF000000F,
                32'h7000000F, 32'h8000000F, 32'hF000000F, 32'hF000000F,
                32'h12345678, 32'h80000001, 32'h00000001, 32'h00000003};
      d_amt = '{32'h00000003, 32'hFFFFFFF5, 32'hFFFFFFF5, 32'h00000010,
                32'h00000004, 32'hFFFFFFFC, 32'h00000020, 32'h00000028,
                32'h80000000, 32'h00000007, 32'h00000020, 32'hFFFFFFE0,
                32'hFFFFFFDF, 32'h00000021, 32'h00000000, 32'hFFFFFFDC,
                32'h00000001, 32'hFFFFFFFF, 32'h0000001F, 32'h0000001F};
      d_mode = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd0,
                 2'd1, 2'd3, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd2,
                 2'd0, 2'd1, 2'd0, 2'd2};
      d_res = '{32'h80000078, 32'h001E0000, 32'hFFFE0000, 32'h000F0000,
                32'h000000FF, 32'hFF000000, 32'hF000000F, 32'h00000000,
                32'hFFFFFFFF, 32'hF000000F, 32'h00000000, 32'h00000000,
                32'h00000000, 32'h00000000, 32'hF000000F, 32'hFF000000,
                32'h2468ACF0, 32'hC0000000, 32'h80000000, 32'h80000001};
      d_cy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
               1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
               1'b0, 1'b1, 1'b0, 1'b1};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_outs", {out_result, out_carry, out_zero, out_tag}, 0);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", in_ready, 1);
      sync();

      for (int i = 0; i < 20; i++) begin
         send(d_arg[i], d_amt[i], d_mode[i], 4'(i), 1, 1,
              d_res[i], d_cy[i]);
         drain();
         sync();
      end

      for (int i = 0; i < 4; i++)
         send((32'h1 << (i * 5)) ^ 32'hA5A50000, 32'(i * 9 - 13),
              2'(i), 4'(i + 3), 1, 0, '0, 1'b0);
      drain();
      sync();

      base = n_acc;
      fork
         begin
            for (int i = 0; i < 6; i++)
               send(32'h80000001 + 32'(i * 32'h1111), 32'(-2 - i * 3),
                    2'(i % 3), 4'(8 + i), 0, 0, '0, 1'b0);
         end
         begin
            out_ready = 1'b0;
            repeat (5) @(negedge clk);
            #1;
            chk("bp_accepts", n_acc - base, 3);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_tag", out_tag, 8);
            sync();
            out_ready = 1'b1;
            repeat (6) begin
               @(negedge clk);
               chk("bp_rate", out_valid, 1);
            end
         end
      join
      drain();
      sync();

      for (int i = 0; i < 3; i++)
         send(32'h0F0F0F0F, 32'(i + 1), 2'd0, 4'(4 + i), 1, 0, '0, 1'b0);
      chk("pre_rst_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_outs", {out_result, out_carry, out_zero, out_tag}, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", in_ready, 1);
      repeat (4) begin
         @(negedge clk);
         chk("no_stale", out_valid, 0);
      end
      sync();
      send(32'hF000000F, 32'h3, 2'd0, 4'hD, 1, 1, 32'h80000078, 1'b1);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end
endmodule
